// File: rtl/scanline_pos_ctrl.sv
// scanline_pos_ctrl: per-frame shadowed scanline controls and per-line relative position tracking.
// Frame start (VSYNC fall) latches config; each DE fall advances the fixed-point line phase.
module scanline_pos_ctrl (
    input  logic        VCLK_i,
    input  logic        nVRST_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    input  logic        sl_en_cfg_i,
    input  logic [7:0]  sl_pos_inc_i,
    input  logic [7:0]  sl_pos_ofs_i,
    input  logic        sl_thickness_cfg_i,
    input  logic [1:0]  sl_profile_cfg_i,
    input  logic [7:0]  sl_strength_cfg_i,
    input  logic [4:0]  sl_bloom_cfg_i,
    output logic        sl_en_o,
    output logic        sl_thickness_o,
    output logic [1:0]  sl_profile_o,
    output logic [7:0]  sl_strength_o,
    output logic [4:0]  sl_bloom_o,
    output logic [7:0]  sl_rel_pos_o,
    output logic [10:0] line_cnt_o
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t      state_q, state_d;
    logic        de_q, vs_q;
    logic        en_sh_q, thick_sh_q;
    logic [1:0]  prof_sh_q;
    logic [4:0]  bloom_sh_q;
    logic [7:0]  inc_sh_q, ofs_sh_q, str_sh_q;
    logic [7:0]  acc_q, acc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  rel_q;
    logic        en_q;
    logic [10:0] cnt_out_q;
    logic        fall_de, fall_vs, step;
    logic        unused_hsync;

    assign unused_hsync = HSYNC_i;
    assign fall_de = de_q & ~DE_i;
    assign fall_vs = vs_q & ~VSYNC_i;
    // A coincident VSYNC fall swallows the DE fall
    assign step = fall_de & ~fall_vs & (state_q != IDLE);

    always_comb begin
        state_d = fall_vs ? ARMED : (fall_de && state_q == ARMED) ? RUN : state_q;
        acc_d   = fall_vs ? 8'd0 : step ? acc_q + inc_sh_q : acc_q;
        cnt_d   = fall_vs ? 11'd0 : (step && cnt_q != 11'd2047) ? cnt_q + 11'd1 : cnt_q;
    end

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            state_q    <= IDLE;
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            en_sh_q    <= 1'b0;
            thick_sh_q <= 1'b0;
            prof_sh_q  <= '0;
            bloom_sh_q <= '0;
            inc_sh_q   <= '0;
            ofs_sh_q   <= '0;
            str_sh_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rel_q      <= '0;
            en_q       <= 1'b0;
            cnt_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            de_q      <= DE_i;
            vs_q      <= VSYNC_i;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rel_q     <= acc_q + ofs_sh_q;
            en_q      <= en_sh_q && state_q != IDLE && inc_sh_q != 8'd0;
            cnt_out_q <= cnt_q;
            if (fall_vs) begin
                en_sh_q    <= sl_en_cfg_i;
                thick_sh_q <= sl_thickness_cfg_i;
                prof_sh_q  <= sl_profile_cfg_i;
                bloom_sh_q <= sl_bloom_cfg_i;
                inc_sh_q   <= sl_pos_inc_i;
                ofs_sh_q   <= sl_pos_ofs_i;
                str_sh_q   <= sl_strength_cfg_i;
            end
        end
    end

    assign sl_en_o        = en_q;
    assign sl_thickness_o = thick_sh_q;
    assign sl_profile_o   = prof_sh_q;
    assign sl_strength_o  = str_sh_q;
    assign sl_bloom_o     = bloom_sh_q;
    assign sl_rel_pos_o   = rel_q;
    assign line_cnt_o     = cnt_out_q;
endmodule

// File: tb/tb_scanline_pos_ctrl.sv
// tb_scanline_pos_ctrl: directed frames/lines; expected outputs queued per sync edge and checked by a monitor.
module tb_scanline_pos_ctrl;
    typedef struct packed {
        logic [7:0]  rel;
        logic [10:0] cnt;
        logic        en;
        logic [7:0]  str;
        logic [7:0]  misc;
    } exp_t;

    logic        vclk = 1'b0;
    logic        nvrst = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1, de = 1'b0;
    logic        en_cfg = 1'b0, thick_cfg = 1'b0;
    logic [7:0]  inc_cfg = '0, ofs_cfg = '0, str_cfg = '0;
    logic [1:0]  prof_cfg = '0;
    logic [4:0]  bloom_cfg = '0;
    logic        sl_en, sl_thick;
    logic [1:0]  sl_prof;
    logic [7:0]  sl_str, sl_rel;
    logic [4:0]  sl_bloom;
    logic [10:0] line_cnt;

    int   checks = 0, failures = 0;
    exp_t sb[$];
    logic pend = 1'b0, de_p = 1'b0, vs_p = 1'b0;

    always #5 vclk = ~vclk;

    scanline_pos_ctrl dut (
        .VCLK_i(vclk), .nVRST_i(nvrst), .HSYNC_i(hsync), .VSYNC_i(vsync), .DE_i(de),
        .sl_en_cfg_i(en_cfg), .sl_pos_inc_i(inc_cfg), .sl_pos_ofs_i(ofs_cfg),
        .sl_thickness_cfg_i(thick_cfg), .sl_profile_cfg_i(prof_cfg),
        .sl_strength_cfg_i(str_cfg), .sl_bloom_cfg_i(bloom_cfg),
        .sl_en_o(sl_en), .sl_thickness_o(sl_thick), .sl_profile_o(sl_prof),
        .sl_strength_o(sl_str), .sl_bloom_o(sl_bloom), .sl_rel_pos_o(sl_rel),
        .line_cnt_o(line_cnt)
    );

    function automatic exp_t actual();
        return '{rel: sl_rel, cnt: line_cnt, en: sl_en, str: sl_str, misc: {sl_thick, sl_prof, sl_bloom}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    // Outputs settle one edge after the edge that detects a sync fall
    initial begin
        exp_t e, a;
        logic fe;
        forever begin
            @(posedge vclk);
            if (!nvrst) begin
                pend = 1'b0; de_p = 1'b0; vs_p = 1'b0;
            end else begin
                if (pend) begin
                    #1;
                    pend = 1'b0;
                    checks++;
                    a = actual();
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_update got rel=%h cnt=%0d", a.rel, a.cnt);
                    end else begin
                        e = sb.pop_front();
                        if (a !== e) begin
                            failures++;
                            $display("FAIL line_out got rel=%h cnt=%0d en=%b str=%h misc=%h expected rel=%h cnt=%0d en=%b str=%h misc=%h",
                                     a.rel, a.cnt, a.en, a.str, a.misc, e.rel, e.cnt, e.en, e.str, e.misc);
                        end
                    end
                end
                fe = (de_p && !de) || (vs_p && !vsync);
                de_p = de; vs_p = vsync; pend = fe;
            end
        end
    end

    task automatic line(input int hi, input logic [7:0] rel, input logic [10:0] cnt,
                        input logic en, input logic [7:0] str, input logic [7:0] misc);
        @(negedge vclk); de = 1'b1; hsync = 1'b1;
        repeat (hi - 1) @(negedge vclk);
        sb.push_back('{rel: rel, cnt: cnt, en: en, str: str, misc: misc});
        @(negedge vclk); de = 1'b0; hsync = 1'b0;
        @(negedge vclk); hsync = 1'b1;
    endtask

    task automatic frame(input logic [7:0] rel, input logic en, input logic [7:0] str, input logic [7:0] misc);
        @(negedge vclk);
        sb.push_back('{rel: rel, cnt: 11'd0, en: en, str: str, misc: misc});
        vsync = 1'b0;
        @(posedge vclk); #1;
        chk("strength_1clk", 64'(sl_str), 64'(str));
        @(negedge vclk);
        @(negedge vclk); vsync = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge vclk);
        chk("reset_outputs", 64'(actual()), 64'd0);
        nvrst = 1'b1;
        // activity with no frame start keeps everything idle
        line(3, 8'h00, 11'd0, 1'b0, 8'h00, 8'h00);
        line(3, 8'h00, 11'd0, 1'b0, 8'h00, 8'h00);
        en_cfg = 1'b1; inc_cfg = 8'h80; ofs_cfg = 8'h40; str_cfg = 8'h80;
        thick_cfg = 1'b1; prof_cfg = 2'd2; bloom_cfg = 5'h11;
        frame(8'h40, 1'b1, 8'h80, 8'hD1);
        line(4, 8'hC0, 11'd1, 1'b1, 8'h80, 8'hD1);
        line(4, 8'h40, 11'd2, 1'b1, 8'h80, 8'hD1);
        str_cfg = 8'hFF; bloom_cfg = 5'h1F;
        line(4, 8'hC0, 11'd3, 1'b1, 8'h80, 8'hD1);
        line(4, 8'h40, 11'd4, 1'b1, 8'h80, 8'hD1);
        inc_cfg = 8'h55; ofs_cfg = 8'h00;
        frame(8'h00, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'h55, 11'd1, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'hAA, 11'd2, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'hFF, 11'd3, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'h54, 11'd4, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'hA9, 11'd5, 1'b1, 8'hFF, 8'hDF);
        // VSYNC and DE fall together: frame start wins
        inc_cfg = 8'h10; ofs_cfg = 8'h20;
        @(negedge vclk); de = 1'b1;
        repeat (2) @(negedge vclk);
        sb.push_back('{rel: 8'h20, cnt: 11'd0, en: 1'b1, str: 8'hFF, misc: 8'hDF});
        de = 1'b0; vsync = 1'b0;
        @(negedge vclk);
        @(negedge vclk); vsync = 1'b1;
        line(4, 8'h30, 11'd1, 1'b1, 8'hFF, 8'hDF);
        inc_cfg = 8'h00; ofs_cfg = 8'h33;
        frame(8'h33, 1'b0, 8'hFF, 8'hDF);
        line(4, 8'h33, 11'd1, 1'b0, 8'hFF, 8'hDF);
        line(4, 8'h33, 11'd2, 1'b0, 8'hFF, 8'hDF);
        inc_cfg = 8'h80; ofs_cfg = 8'h40;
        frame(8'h40, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'hC0, 11'd1, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'h40, 11'd2, 1'b1, 8'hFF, 8'hDF);
        // asynchronous reset in the middle of line 3
        @(negedge vclk); de = 1'b1;
        @(negedge vclk); #3 nvrst = 1'b0;
        #1 chk("async_reset", 64'(actual()), 64'd0);
        @(negedge vclk);
        @(negedge vclk); nvrst = 1'b1;
        @(negedge vclk);
        sb.push_back('{rel: 8'h00, cnt: 11'd0, en: 1'b0, str: 8'h00, misc: 8'h00});
        @(negedge vclk); de = 1'b0;
        @(negedge vclk);
        line(4, 8'h00, 11'd0, 1'b0, 8'h00, 8'h00);
        frame(8'h40, 1'b1, 8'hFF, 8'hDF);
        line(4, 8'hC0, 11'd1, 1'b1, 8'hFF, 8'hDF);
        inc_cfg = 8'h01; ofs_cfg = 8'h00;
        frame(8'h00, 1'b1, 8'hFF, 8'hDF);
        for (int i = 1; i <= 2100; i++)
            line(1, 8'(i), (i > 2047) ? 11'd2047 : 11'(i), 1'b1, 8'hFF, 8'hDF);
        for (int i = 0; i < 20 && (sb.size() != 0 || pend); i++) @(negedge vclk);
        if (sb.size() != 0 || pend) begin
            failures++;
            $display("FAIL drain got pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/scanline_pos_ctrl.md
SCANLINE_POS_CTRL -- requirements
Module: scanline_pos_ctrl

Interface
REQ-001 SHALL have port VCLK_i, input, 1 bit: pixel clock; the only clock.
REQ-002 SHALL have port nVRST_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port HSYNC_i, input, 1 bit: horizontal sync, active-low; informational only, not used for sequencing.
REQ-004 SHALL have port VSYNC_i, input, 1 bit: vertical sync, active-low; its falling edge marks frame start.
REQ-005 SHALL have port DE_i, input, 1 bit: data enable, active-high; its falling edge marks the end of an active line.
REQ-006 SHALL have port sl_en_cfg_i, input, 1 bit: scanlines requested.
REQ-007 SHALL have port sl_pos_inc_i, input, 8 bits: relative-position step per output line, unsigned 0.8 fixed point (256 / vertical scale factor).
REQ-008 SHALL have port sl_pos_ofs_i, input, 8 bits: phase offset of the first line, 0.8 fixed point.
REQ-009 SHALL have port sl_thickness_cfg_i, input, 1 bit: scanline thickness setting.
REQ-010 SHALL have port sl_profile_cfg_i, input, 2 bits: scanline profile setting.
REQ-011 SHALL have port sl_strength_cfg_i, input, 8 bits: scanline strength setting.
REQ-012 SHALL have port sl_bloom_cfg_i, input, 5 bits: bloom setting.
REQ-013 SHALL have ports sl_en_o (1), sl_thickness_o (1), sl_profile_o (2), sl_strength_o (8), sl_bloom_o (5), all outputs: frame-stable scanline controls for the scanline datapath.
REQ-014 SHALL have port sl_rel_pos_o, output, 8 bits: relative position of the current output line within its source line.
REQ-015 SHALL have port line_cnt_o, output, 11 bits: number of active lines completed in the current frame.

Function
REQ-016 SHALL register DE_i and VSYNC_i once; fall_de = DE_q & ~DE_i; fall_vs = VSYNC_q & ~VSYNC_i.
REQ-017 SHALL implement FSM states IDLE, ARMED and RUN.
REQ-018 SHALL move from IDLE to ARMED on fall_vs.
REQ-019 SHALL move from ARMED to RUN on the first fall_de.
REQ-020 SHALL move from RUN back to ARMED on fall_vs.
REQ-021 SHALL leave ARMED and RUN only on a VSYNC or DE edge; no other transitions.
REQ-022 On each fall_vs, SHALL shadow all *_cfg_i, sl_pos_inc_i and sl_pos_ofs_i into internal registers, then clear acc (8 bits) to 0 and line_cnt to 0.
REQ-023 Changes of config inputs outside fall_vs SHALL have no effect on any output.
REQ-024 On fall_de in ARMED or RUN, SHALL compute acc <= acc + inc_shadow modulo 256 (carry discarded) and line_cnt <= line_cnt + 1, saturating at 2047.
REQ-025 SHALL drive sl_rel_pos_o as registered (acc + ofs_shadow) mod 256; it updates one VCLK after the cycle in which fall_de or fall_vs is detected, and is constant while DE is high.
REQ-026 SHALL drive sl_en_o = en_shadow AND (state != IDLE) AND (inc_shadow != 0), registered.
REQ-027 SHALL drive sl_thickness_o, sl_profile_o, sl_strength_o and sl_bloom_o directly from the shadow registers.
REQ-028 SHALL drive line_cnt_o from line_cnt, registered.
REQ-029 If fall_vs and fall_de occur in the same cycle, fall_vs SHALL take priority and the DE edge SHALL be ignored.
REQ-030 fall_de in IDLE SHALL be ignored, with acc and line_cnt unchanged.
REQ-031 With inc_shadow = 0, acc SHALL stay 0 and sl_rel_pos_o SHALL equal ofs_shadow.
REQ-032 Total output latency from an input edge to an output update SHALL be exactly 2 VCLK from the input pin.

Reset
REQ-033 While nVRST_i = 0, all outputs, shadows, acc, line_cnt, DE_q and VSYNC_q SHALL be 0 and the state SHALL be IDLE.
REQ-034 Assertion of nVRST_i mid-frame SHALL take effect immediately (asynchronous); after release, the block SHALL wait in IDLE for the next fall_vs.
REQ-035 Release of nVRST_i SHALL be synchronised externally; the block SHALL require no internal sequencing after release.

Verification
REQ-036 Set inc=0x80, ofs=0x40, en=1; drive one VSYNC, then 4 lines -> sl_rel_pos_o = 0x40, 0xC0, 0x40, 0xC0 per line; sl_en_o = 1; line_cnt_o = 4.
REQ-037 Set inc=0x55, ofs=0; run 5 lines -> sl_rel_pos_o = 0x00, 0x55, 0xAA, 0xFF, 0x54 (wrap).
REQ-038 Change strength 0x80->0xFF mid-frame -> sl_strength_o stays 0x80 until the next fall_vs, then becomes 0xFF 1 VCLK later.
REQ-039 Hold DE/VSYNC activity with no VSYNC after reset -> sl_en_o = 0, sl_rel_pos_o = 0, line_cnt_o = 0.
REQ-040 Assert fall_vs and fall_de in the same cycle -> acc = 0, line_cnt_o = 0, sl_rel_pos_o = ofs.
REQ-041 Pulse nVRST_i low during line 3 -> all outputs 0 within 0 VCLK; resume only after the next VSYNC; run 2100 lines in one frame -> line_cnt_o saturates at 2047.
